fft_output_rotator: RTL and testbench

- Parametrised successor of the radix-4 output lane mixer.
- Cyclically rotates LANES complex samples across output lanes behind one registered pipeline stage.
- Adds valid/ready flow control, left/right rotation direction, and an auto-sequencing rotation counter for the butterfly-to-memory write path.
- Sits between the butterfly output stage and the bank-write logic of the FFT core.

---
 rtl/fft_output_rotator.sv | 88 ++++++++
 tb/tb_fft_output_rotator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_rotator.sv
// Rotates LANES complex samples across the output lanes. The rotation comes from iSEL or from an
// internal sequencing counter, and the result is held in one registered valid/ready stage.
// Optional macro FFT_OUT_ROT_CONJ_EN adds saturated imag negation on request.
`timescale 1ns/1ps

module fft_output_rotator #(
  parameter int BIT   = 17,
  parameter int LANES = 4,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iVALID,
  output logic                   oREADY,
  input  logic                   iAUTO,
  input  logic                   iSYNC,
  input  logic [SEL_W-1:0]       iSEL,
  input  logic                   iDIR,
  input  logic                   iCONJ,
  input  logic [LANES*BIT-1:0]   iRE,
  input  logic [LANES*BIT-1:0]   iIM,
  output logic                   oVALID,
  input  logic                   iREADY,
  output logic [LANES*BIT-1:0]   oRE,
  output logic [LANES*BIT-1:0]   oIM,
  output logic [SEL_W-1:0]       oROT
);

  logic                 accept;
  logic [SEL_W-1:0]     autoCnt;
  logic [SEL_W-1:0]     rot;
  logic [SEL_W-1:0]     src;
  logic [BIT-1:0]       laneIm;
  logic [LANES*BIT-1:0] rotRe;
  logic [LANES*BIT-1:0] rotIm;

  assign oREADY = !oVALID || iREADY;
  assign accept = iVALID && oREADY;

  always_comb begin
    rot = iSEL;
    if (iAUTO) rot = iSYNC ? '0 : autoCnt;
  end

`ifdef FFT_OUT_ROT_CONJ_EN
  localparam logic [BIT-1:0] MIN_VAL = {1'b1, {(BIT-1){1'b0}}};
  localparam logic [BIT-1:0] MAX_VAL = ~MIN_VAL;
`else
  logic unusedConj;
  assign unusedConj = iCONJ;
`endif

  // LANES is a power of two, so SEL_W-bit wraparound gives the mod-LANES lane index
  always_comb begin
    rotRe  = '0;
    rotIm  = '0;
    src    = '0;
    laneIm = '0;
    for (int k = 0; k < LANES; k++) begin
      src    = iDIR ? (SEL_W'(k) - rot) : (SEL_W'(k) + rot);
      laneIm = iIM[int'(src)*BIT +: BIT];
`ifdef FFT_OUT_ROT_CONJ_EN
      if (iCONJ) laneIm = (laneIm == MIN_VAL) ? MAX_VAL : -laneIm;
`endif
      rotRe[k*BIT +: BIT] = iRE[int'(src)*BIT +: BIT];
      rotIm[k*BIT +: BIT] = laneIm;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oVALID  <= 1'b0;
      oRE     <= '0;
      oIM     <= '0;
      oROT    <= '0;
      autoCnt <= '0;
    end else if (accept) begin
      oVALID <= 1'b1;
      oRE    <= rotRe;
      oIM    <= rotIm;
      oROT   <= rot;
      if (iAUTO) autoCnt <= iSYNC ? SEL_W'(1) : autoCnt + SEL_W'(1);
    end else if (iREADY) begin
      oVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_output_rotator.sv
// Scoreboard bench for fft_output_rotator: the driver pushes expected beats from a lane-index model
// and an independent monitor pops and compares each beat that retires.
`timescale 1ns/1ps

module tb_fft_output_rotator;
  localparam int BIT   = 17;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int W     = LANES * BIT;
`ifdef FFT_OUT_ROT_CONJ_EN
  localparam bit CONJ_ON = 1'b1;
`else
  localparam bit CONJ_ON = 1'b0;
`endif

  logic iCLK = 1'b0, iRESET = 1'b0, iVALID = 1'b0, iAUTO = 1'b0, iSYNC = 1'b0;
  logic iDIR = 1'b0, iCONJ = 1'b0, iREADY = 1'b1;
  logic [SEL_W-1:0] iSEL = '0;
  logic [W-1:0] iRE = '0, iIM = '0;
  logic oREADY, oVALID;
  logic [W-1:0] oRE, oIM;
  logic [SEL_W-1:0] oROT;

  typedef struct {
    logic [W-1:0]     re;
    logic [W-1:0]     im;
    logic [SEL_W-1:0] rot;
  } beat_t;

  beat_t sbQ[$];
  int checkCount = 0;
  int failCount  = 0;
  int modelCnt   = 0;

  fft_output_rotator #(.BIT(BIT), .LANES(LANES)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(oREADY), .iAUTO(iAUTO),
    .iSYNC(iSYNC), .iSEL(iSEL), .iDIR(iDIR), .iCONJ(iCONJ), .iRE(iRE), .iIM(iIM),
    .oVALID(oVALID), .iREADY(iREADY), .oRE(oRE), .oIM(oIM), .oROT(oROT)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [W-1:0] v;
    v = '0;
    v[0*BIT +: BIT] = BIT'(l0);
    v[1*BIT +: BIT] = BIT'(l1);
    v[2*BIT +: BIT] = BIT'(l2);
    v[3*BIT +: BIT] = BIT'(l3);
    return v;
  endfunction

  // Expected beat straight from the lane formulas, with integer negation and clamping
  function automatic beat_t modelBeat(input bit autoMode, input bit sync, input int sel, input bit dir,
                                      input bit conj, input logic [W-1:0] re, input logic [W-1:0] im);
    beat_t b;
    int r, srcLane, imVal;
    logic signed [BIT-1:0] lane;
    r = autoMode ? (sync ? 0 : modelCnt) : sel;
    for (int k = 0; k < LANES; k++) begin
      srcLane = dir ? (k - r + LANES) % LANES : (k + r) % LANES;
      b.re[k*BIT +: BIT] = re[srcLane*BIT +: BIT];
      lane  = im[srcLane*BIT +: BIT];
      imVal = int'(lane);
      if (conj && CONJ_ON) begin
        imVal = -imVal;
        if (imVal > (1 << (BIT-1)) - 1) imVal = (1 << (BIT-1)) - 1;
      end
      b.im[k*BIT +: BIT] = BIT'(imVal);
    end
    b.rot = SEL_W'(r);
    return b;
  endfunction

  task automatic applyStimulus(input bit valid, input bit autoMode, input bit sync, input int sel,
                               input bit dir, input bit conj, input logic [W-1:0] re,
                               input logic [W-1:0] im, input bit rdy);
    iVALID = valid; iAUTO = autoMode; iSYNC = sync; iSEL = SEL_W'(sel);
    iDIR = dir; iCONJ = conj; iRE = re; iIM = im; iREADY = rdy;
    @(negedge iCLK);
    if (iRESET && iVALID && oREADY) begin
      sbQ.push_back(modelBeat(autoMode, sync, sel, dir, conj, re, im));
      if (autoMode) modelCnt = sync ? (1 % LANES) : (modelCnt + 1) % LANES;
    end
    @(posedge iCLK);
    #1;
  endtask

  always @(negedge iCLK) begin
    if (iRESET && oVALID && iREADY) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedBeat", 128'd1, 128'd0);
      end else begin
        beat_t e;
        e = sbQ.pop_front();
        checkOutput("beatRe", 128'(oRE), 128'(e.re));
        checkOutput("beatIm", 128'(oIM), 128'(e.im));
        checkOutput("beatRot", 128'(oROT), 128'(e.rot));
      end
    end
  end

  initial begin
    #200000;
    failCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  initial begin
    int autoRot[8];
    logic [W-1:0] heldRe;
    logic [SEL_W-1:0] heldRot;
    logic [W-1:0] rr, ri;
    autoRot = '{0, 1, 2, 3, 0, 1, 0, 1};

    #12;
    checkOutput("resetValid", 128'(oVALID), 128'd0);
    checkOutput("resetRe", 128'(oRE), 128'd0);
    checkOutput("resetIm", 128'(oIM), 128'd0);
    checkOutput("resetRot", 128'(oROT), 128'd0);
    checkOutput("resetReady", 128'(oREADY), 128'd1);
    @(negedge iCLK); iRESET = 1'b1;
    @(posedge iCLK); #1;

    applyStimulus(1, 0, 0, 1, 0, 0, pack4(10, 20, 30, 40), pack4(-1, -2, -3, -4), 1);
    checkOutput("leftSel1Re", 128'(oRE), 128'(pack4(20, 30, 40, 10)));
    checkOutput("leftSel1Rot", 128'(oROT), 128'd1);
    applyStimulus(1, 0, 0, 1, 1, 0, pack4(10, 20, 30, 40), pack4(-1, -2, -3, -4), 1);
    checkOutput("rightSel1Re", 128'(oRE), 128'(pack4(40, 10, 20, 30)));

    for (int d = 0; d < 2; d++)
      for (int s = 0; s < LANES; s++)
        applyStimulus(1, 0, 0, s, d[0], 0, pack4(10, 20, 30, 40), pack4(7, -8, 9, -10), 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, (i == 0 || i == 6), 0, 0, 0, pack4(i, i+1, i+2, i+3), pack4(-i, 5, 6, 7), 1);
      checkOutput("autoRot", 128'(oROT), 128'(autoRot[i]));
    end

    applyStimulus(1, 1, 0, 0, 0, 0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1);
    heldRe  = sbQ[0].re;
    heldRot = sbQ[0].rot;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 0, pack4(100, 200, 300, 400), pack4(1, 1, 1, 1), 0);
      checkOutput("stallReady", 128'(oREADY), 128'd0);
      checkOutput("stallHoldRe", 128'(oRE), 128'(heldRe));
      checkOutput("stallHoldRot", 128'(oROT), 128'(heldRot));
    end
    applyStimulus(1, 1, 0, 0, 1, 0, pack4(100, 200, 300, 400), pack4(1, 1, 1, 1), 1);
    checkOutput("noBubbleValid", 128'(oVALID), 128'd1);
    checkOutput("noBubbleQueue", 128'(sbQ.size()), 128'd1);

    applyStimulus(1, 0, 0, 2, 0, 0, pack4(11, 22, 33, 44), pack4(1, 2, 3, 4), 1);
    iVALID = 1'b0; iREADY = 1'b0;
    #1;
    checkOutput("preResetValid", 128'(oVALID), 128'd1);
    iRESET = 1'b0;
    #1;
    checkOutput("midResetValid", 128'(oVALID), 128'd0);
    checkOutput("midResetRe", 128'(oRE), 128'd0);
    sbQ.delete();
    modelCnt = 0;
    @(negedge iCLK); iRESET = 1'b1;
    @(posedge iCLK); #1;
    applyStimulus(1, 1, 0, 0, 0, 0, pack4(9, 8, 7, 6), pack4(1, 2, 3, 4), 1);
    checkOutput("postResetAutoRot", 128'(oROT), 128'd0);

    applyStimulus(1, 0, 0, 0, 0, 1, pack4(1, 2, 3, 4), pack4(5, -65536, 65535, 0), 1);
    checkOutput("conjIm", 128'(oIM),
                CONJ_ON ? 128'(pack4(-5, 65535, -65535, 0)) : 128'(pack4(5, -65536, 65535, 0)));

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < LANES; k++) begin
        rr[k*BIT +: BIT] = BIT'($urandom);
        ri[k*BIT +: BIT] = ($urandom_range(0, 5) == 0) ? {1'b1, {(BIT-1){1'b0}}} : BIT'($urandom);
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                    int'($urandom_range(0, LANES-1)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, rr, ri, $urandom_range(0, 9) < 7);
    end

    iVALID = 1'b0; iREADY = 1'b1;
    for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(posedge iCLK);
    #1;
    checkOutput("drainEmpty", 128'(sbQ.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
